// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INST_DEF = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_DROP = 3'd3,
    ST_HOLD = 3'd4
  } state_t;
endpackage

// File: rtl/fetch_out_buf.sv
// Single-entry output slot toward decode: load from memory, flush on redirect,
// pop on the valid/ready handshake.
module fetch_out_buf
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [XLEN-1:0] load_inst,
  input  logic [XLEN-1:0] load_pc,
  input  logic            flush,
  input  logic            if_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] if_inst,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc4
);
  // Flush beats a same-cycle pop so a handshake under redirect is void.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_valid <= 1'b0;
      if_inst  <= NOP_INST;
      if_pc    <= RESET_PC;
      if_pc4   <= RESET_PC + 32'd4;
    end else if (flush) begin
      if_valid <= 1'b0;
      if_inst  <= NOP_INST;
    end else if (load) begin
      if_valid <= 1'b1;
      if_inst  <= load_inst;
      if_pc    <= load_pc;
      if_pc4   <= load_pc + 32'd4;
    end else if (if_valid && if_ready) begin
      if_valid <= 1'b0;
      if_inst  <= NOP_INST;
    end
  end
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives the request/grant/response memory port
// and feeds the output slot. Redirects cancel or discard any in-flight fetch.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_inst,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc4,
  output state_t          dbg_state
);
  // Handshakes: imem_req/imem_addr are held until the cycle imem_gnt is seen;
  // imem_rvalid is honoured only in WAIT/DROP; decode pops when if_valid && if_ready.
  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] redirect_tgt;
  logic            slot_load;

  assign redirect_tgt = redirect_pc & ~32'h3;
  assign slot_load    = (state == ST_WAIT) && imem_rvalid && !redirect_valid;
  assign dbg_state    = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else if (redirect_valid) begin
      pc        <= redirect_tgt;
      imem_addr <= redirect_tgt;
      imem_req  <= 1'b0;
      case (state)
        ST_IDLE, ST_HOLD: begin
          state    <= ST_REQ;
          imem_req <= 1'b1;
        end
        ST_REQ:  state <= imem_gnt ? ST_DROP : ST_IDLE;
        ST_WAIT, ST_DROP: begin
          if (imem_rvalid) begin
            state    <= ST_REQ;
            imem_req <= 1'b1;
          end else begin
            state <= ST_DROP;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end else begin
      case (state)
        ST_IDLE: begin
          state     <= ST_REQ;
          imem_req  <= 1'b1;
          imem_addr <= pc;
        end
        ST_REQ: begin
          if (imem_gnt) begin
            state    <= ST_WAIT;
            imem_req <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            state <= ST_HOLD;
            pc    <= pc + 32'd4;
          end
        end
        ST_DROP: begin
          if (imem_rvalid) begin
            state     <= ST_REQ;
            imem_req  <= 1'b1;
            imem_addr <= pc;
          end
        end
        ST_HOLD: begin
          // The next request waits for the slot to drain, so a response never finds it full.
          if (if_ready) begin
            state     <= ST_REQ;
            imem_req  <= 1'b1;
            imem_addr <= pc;
          end
        end
        default: begin
          state    <= ST_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  fetch_out_buf #(
    .RESET_PC(RESET_PC),
    .NOP_INST(NOP_INST)
  ) u_out_buf (
    .clk      (clk),
    .reset    (reset),
    .load     (slot_load),
    .load_inst(imem_rdata),
    .load_pc  (pc),
    .flush    (redirect_valid),
    .if_ready (if_ready),
    .if_valid (if_valid),
    .if_inst  (if_inst),
    .if_pc    (if_pc),
    .if_pc4   (if_pc4)
  );
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the core's front end. It owns the architectural PC and drives a variable-latency instruction memory through a request/grant/response handshake. It delivers one fetched instruction at a time to decode over a valid/ready interface. Control-flow redirects from execute (branch/jump target) flush the output and cancel or discard any in-flight fetch.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, value of if_inst while no valid instruction is held.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  execute resolves a taken branch or jump this cycle.
- redirect_pc  in  32  target PC; bits [1:0] are ignored (treated as 0).
- imem_req  out  1  fetch request (registered).
- imem_addr  out  32  fetch address (registered), equals the current PC.
- imem_gnt  in  1  memory accepts the request in this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  32  instruction word.
- if_valid  out  1  output slot holds a valid instruction.
- if_ready  in  1  decode accepts the instruction.
- if_inst  out  32  instruction.
- if_pc  out  32  PC of if_inst.
- if_pc4  out  32  if_pc + 4 (mod 2^32).

## Operation
States:
- IDLE: one-cycle gap, request low.
- REQ: imem_req=1.
- WAIT: granted, awaiting response.
- DROP: awaiting response of a cancelled fetch.
- HOLD: output slot full.

Normal flow:
- IDLE -> REQ.
- REQ & gnt -> WAIT.
- WAIT & rvalid -> HOLD. Load the slot with {pc, rdata}, set if_valid, and set pc <= pc + 4 (wraps at 2^32).
- HOLD & if_ready -> REQ. The slot clears in the same edge.
- At most one outstanding request.
- A new request is issued only when the slot is empty, so a response never finds the slot full.

Redirect has the highest priority. In every state it sets pc <= {redirect_pc[31:2],2'b00} and clears if_valid. Next state by current state:
- IDLE or HOLD: -> REQ.
- REQ without gnt: -> IDLE. imem_req drops for one cycle; the request is never committed without a grant.
- REQ with gnt in the same cycle: -> DROP.
- WAIT without rvalid: -> DROP.
- WAIT with rvalid in the same cycle: the response is discarded -> REQ.
- DROP without rvalid: stay in DROP; only pc updates.
- DROP with rvalid: -> REQ.

Other rules:
- DROP & rvalid (no redirect): discard the response -> REQ.
- if_ready is ignored while if_valid=0. A handshake in the same cycle as a redirect is void.
- imem_rvalid outside WAIT/DROP is a protocol error and is ignored.

Reset (any time, asynchronous):
- state=IDLE, pc=RESET_PC.
- imem_req=0, imem_addr=RESET_PC.
- if_valid=0, if_inst=NOP_INST, if_pc=RESET_PC, if_pc4=RESET_PC+4.
- An in-flight memory response after reset is the memory's responsibility; memory is reset by the same signal.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- imem_req/imem_addr hold stable from assertion until the gnt cycle, except for a redirect, which deasserts req.
- Memory contract: rvalid arrives at least 1 cycle after gnt, never in the gnt cycle.
- Zero-wait memory, with reset released before edge 0:
  - imem_req high in cycle 1.
  - gnt in cycle 1, rvalid in cycle 2.
  - if_valid high in cycle 3.
- With continuous if_ready and a zero-wait memory, steady-state throughput is 1 instruction per 3 cycles (REQ, WAIT, HOLD).
- Redirect at edge t: new pc is visible on imem_addr with imem_req=1 at t+1 (or t+2 via IDLE/DROP).

## Structure
- Shared package fetch_pkg:
  - state enum (IDLE, REQ, WAIT, DROP, HOLD).
  - NOP_INST and RESET_PC defaults.
  - XLEN=32 constant.
- One natural sub-module: fetch_out_buf, a single-entry output slot with load, flush and valid/ready pop, producing if_inst/if_pc/if_pc4.
- PC register and FSM live in fetch_ctrl.

## Test plan
- Reset release, zero-wait memory, rdata=32'h00500093, if_ready=1 -> if_valid in cycle 3 with if_pc=0, if_pc4=4; next imem_addr=4 in cycle 4.
- Memory gnt delayed 3 cycles and rvalid 2 cycles after gnt -> imem_addr stable at 0 while req is high; exactly one instruction delivered.
- if_ready=0 for 5 cycles while HOLD -> if_inst/if_pc stable, imem_req=0; if_ready=1 -> REQ next cycle, addr=pc+4.
- redirect_valid with redirect_pc=32'h0000_0103 while in WAIT -> old response discarded (no if_valid); next request addr=32'h0000_0100; delivered if_pc=32'h100.
- Redirect in HOLD with if_ready=1 in the same cycle -> slot flushed, no handshake counted; next fetch at the redirect target.
- Fetch at pc=32'hFFFF_FFFC -> if_pc4=0; next imem_addr=0. Reset asserted mid-WAIT -> all outputs return to reset values immediately.
